// File: rtl/vc_io_pkg.sv
// Shared definitions for the vc I/O bus windows and the timer register map.
package vc_io_pkg;

  // Byte data width of the I/O bus and register-select width
  localparam int unsigned IO_DW = 8;
  localparam int unsigned IO_AW = 4;

  // Window IDs decoded from addr[7:5]
  localparam logic [2:0] IO_QSPI  = 3'd0;
  localparam logic [2:0] IO_UART  = 3'd1;
  localparam logic [2:0] IO_TIMER = 3'd2;

  // Timer register offsets (io_addr)
  localparam logic [IO_AW-1:0] TMR_CTRL   = 4'd0;
  localparam logic [IO_AW-1:0] TMR_STATUS = 4'd1;
  localparam logic [IO_AW-1:0] TMR_PRESC  = 4'd2;
  localparam logic [IO_AW-1:0] TMR_CMP_LO = 4'd3;
  localparam logic [IO_AW-1:0] TMR_CMP_HI = 4'd4;
  localparam logic [IO_AW-1:0] TMR_CNT_LO = 4'd5;
  localparam logic [IO_AW-1:0] TMR_CNT_HI = 4'd6;

  // CTRL bit indices
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_IE       = 1;
  localparam int unsigned CTRL_PERIODIC = 2;

  // STATUS bit index
  localparam int unsigned STATUS_PEND = 0;

  // Architectural CTRL contents
  typedef struct packed {
    logic periodic;
    logic ie;
    logic en;
  } tmr_ctrl_t;

  // Unpack a CTRL write byte; unused bits are dropped
  function automatic tmr_ctrl_t byte_to_ctrl(input logic [IO_DW-1:0] b);
    tmr_ctrl_t c;
    c.en       = b[CTRL_EN];
    c.ie       = b[CTRL_IE];
    c.periodic = b[CTRL_PERIODIC];
    return c;
  endfunction

  // Pack CTRL for readback; unused bits read 0
  function automatic logic [IO_DW-1:0] ctrl_to_byte(input tmr_ctrl_t c);
    logic [IO_DW-1:0] b;
    b                = '0;
    b[CTRL_EN]       = c.en;
    b[CTRL_IE]       = c.ie;
    b[CTRL_PERIODIC] = c.periodic;
    return b;
  endfunction

endpackage

// File: rtl/io_timer_tick_gen.sv
// Prescaler: counts 0..presc while enabled and flags the wrap cycle as a tick.
module tick_gen
  import vc_io_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [PW-1:0] presc,
  output logic          tick
);

  logic [PW-1:0] r_pcnt;
  logic          w_wrap;

  // A tick is the cycle whose edge wraps pcnt back to 0; a presc below pcnt runs through the natural overflow
  assign w_wrap = en && (r_pcnt == presc);
  assign tick   = w_wrap;

  // Prescale counter, held at 0 while disabled
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pcnt <= '0;
    end else if (!en || w_wrap) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped 16-bit prescaled timer with compare match and level interrupt.
module io_timer
  import vc_io_pkg::*;
#(
  parameter int unsigned CW = 16,
  parameter int unsigned PW = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] io_addr,
  input  logic       io_write,
  input  logic       io_read,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       interrupt
);

  // Upper byte of the 16-bit counter/compare registers
  localparam int unsigned HI_LSB = 8;

  tmr_ctrl_t     r_ctrl;
  logic          r_pend;
  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_cmp;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_hi_shadow;
  logic          r_interrupt;

  logic          w_tick;
  logic          w_wr_ctrl;
  logic          w_wr_status;
  logic          w_wr_presc;
  logic          w_wr_cmp_lo;
  logic          w_wr_cmp_hi;
  logic          w_wr_cnt_lo;
  logic          w_wr_cnt_hi;
  logic          w_cnt_wr;
  logic          w_match;
  logic          w_pend_set;
  logic          w_pend_clr;
  logic          w_pend_nxt;
  logic          w_shadow_ld;
  tmr_ctrl_t     w_ctrl_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [7:0]    w_rdata;

  // Register write decode
  assign w_wr_ctrl   = io_write && (io_addr == TMR_CTRL);
  assign w_wr_status = io_write && (io_addr == TMR_STATUS);
  assign w_wr_presc  = io_write && (io_addr == TMR_PRESC);
  assign w_wr_cmp_lo = io_write && (io_addr == TMR_CMP_LO);
  assign w_wr_cmp_hi = io_write && (io_addr == TMR_CMP_HI);
  assign w_wr_cnt_lo = io_write && (io_addr == TMR_CNT_LO);
  assign w_wr_cnt_hi = io_write && (io_addr == TMR_CNT_HI);
  assign w_cnt_wr    = w_wr_cnt_lo || w_wr_cnt_hi;

  // Reading CNT_LO latches the high byte so a following CNT_HI read is coherent
  assign w_shadow_ld = io_read && (io_addr == TMR_CNT_LO);

  assign w_match = (r_cnt == r_cmp);

  tick_gen #(
    .PW (PW)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (r_ctrl.en),
    .presc (r_presc),
    .tick  (w_tick)
  );

  // Counter/CTRL next state: a CNT write suppresses the tick for that cycle, a CTRL write overrides one-shot stop
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    w_cnt_nxt  = r_cnt;
    w_pend_set = 1'b0;
    if (w_tick && !w_cnt_wr) begin
      if (w_match) begin
        w_pend_set = 1'b1;
        if (r_ctrl.periodic) begin
          w_cnt_nxt = '0;
        end else begin
          w_ctrl_nxt.en = 1'b0;
        end
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
    if (w_wr_ctrl) begin
      w_ctrl_nxt = byte_to_ctrl(io_wdata);
    end
    if (w_wr_cnt_lo) begin
      w_cnt_nxt[HI_LSB-1:0] = io_wdata;
    end
    if (w_wr_cnt_hi) begin
      w_cnt_nxt[CW-1:HI_LSB] = io_wdata;
    end
  end

  // PEND is write-1-to-clear; a simultaneous match keeps it set
  assign w_pend_clr = w_wr_status && io_wdata[STATUS_PEND];
  assign w_pend_nxt = w_pend_set || (r_pend && !w_pend_clr);

  // Timer state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ctrl      <= '0;
      r_pend      <= 1'b0;
      r_presc     <= '0;
      r_cmp       <= '0;
      r_cnt       <= '0;
      r_hi_shadow <= '0;
      r_interrupt <= 1'b0;
    end else begin
      r_ctrl      <= w_ctrl_nxt;
      r_pend      <= w_pend_nxt;
      r_cnt       <= w_cnt_nxt;
      r_interrupt <= r_pend && r_ctrl.ie;
      if (w_wr_presc) begin
        r_presc <= PW'(io_wdata);
      end
      if (w_wr_cmp_lo) begin
        r_cmp[HI_LSB-1:0] <= io_wdata;
      end
      if (w_wr_cmp_hi) begin
        r_cmp[CW-1:HI_LSB] <= io_wdata;
      end
      if (w_shadow_ld) begin
        r_hi_shadow <= r_cnt[CW-1:HI_LSB];
      end
    end
  end

  // Combinational readback mux
  always_comb begin
    w_rdata = '0;
    case (io_addr)
      TMR_CTRL:   w_rdata = ctrl_to_byte(r_ctrl);
      TMR_STATUS: w_rdata[STATUS_PEND] = r_pend;
      TMR_PRESC:  w_rdata = 8'(r_presc);
      TMR_CMP_LO: w_rdata = r_cmp[HI_LSB-1:0];
      TMR_CMP_HI: w_rdata = r_cmp[CW-1:HI_LSB];
      TMR_CNT_LO: w_rdata = r_cnt[HI_LSB-1:0];
      TMR_CNT_HI: w_rdata = r_hi_shadow;
      default:    w_rdata = '0;
    endcase
  end

  assign io_rdata  = w_rdata;
  assign interrupt = r_interrupt;

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: directed scenarios plus randomized traffic against a behavioural model.
module tb_io_timer;
  import vc_io_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] io_addr;
  logic       io_write;
  logic       io_read;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       interrupt;

  int n_vec;
  int n_err;

  // Behavioural model state (architectural view of the timer)
  bit m_en, m_ie, m_per, m_pend, m_irq;
  int m_presc, m_pcnt, m_cmp, m_cnt, m_shadow;

  io_timer #(
    .CW (16),
    .PW (8)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .io_addr   (io_addr),
    .io_write  (io_write),
    .io_read   (io_read),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_rdata(input logic [3:0] a);
    case (a)
      TMR_CTRL:   return int'(m_en) + 2 * int'(m_ie) + 4 * int'(m_per);
      TMR_STATUS: return int'(m_pend);
      TMR_PRESC:  return m_presc;
      TMR_CMP_LO: return m_cmp % 256;
      TMR_CMP_HI: return m_cmp / 256;
      TMR_CNT_LO: return m_cnt % 256;
      TMR_CNT_HI: return m_shadow;
      default:    return 0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    bit tick, cnt_wr, hit, n_en;
    int n_pcnt, n_cnt;
    if (!rst_n) begin
      m_en = 0; m_ie = 0; m_per = 0; m_pend = 0; m_irq = 0;
      m_presc = 0; m_pcnt = 0; m_cmp = 0; m_cnt = 0; m_shadow = 0;
      return;
    end
    tick   = m_en && (m_pcnt == m_presc);
    n_pcnt = (m_en && !tick) ? (m_pcnt + 1) % 256 : 0;
    cnt_wr = io_write && (io_addr == TMR_CNT_LO || io_addr == TMR_CNT_HI);
    hit    = tick && !cnt_wr && (m_cnt == m_cmp);
    n_cnt  = m_cnt;
    n_en   = m_en;
    if (tick && !cnt_wr) begin
      if (!hit)       n_cnt = (m_cnt + 1) % 65536;
      else if (m_per) n_cnt = 0;
      else            n_en  = 0;
    end
    m_irq  = m_pend && m_ie;
    m_pend = hit || (m_pend && !(io_write && io_addr == TMR_STATUS && io_wdata[0]));
    if (io_read && io_addr == TMR_CNT_LO) m_shadow = m_cnt / 256;
    if (io_write) begin
      case (io_addr)
        TMR_CTRL: begin
          n_en  = io_wdata[0];
          m_ie  = io_wdata[1];
          m_per = io_wdata[2];
        end
        TMR_PRESC:  m_presc = int'(io_wdata);
        TMR_CMP_LO: m_cmp   = (m_cmp / 256) * 256 + int'(io_wdata);
        TMR_CMP_HI: m_cmp   = (m_cmp % 256) + int'(io_wdata) * 256;
        TMR_CNT_LO: n_cnt   = (m_cnt / 256) * 256 + int'(io_wdata);
        TMR_CNT_HI: n_cnt   = (m_cnt % 256) + int'(io_wdata) * 256;
        default: ;
      endcase
    end
    m_en   = n_en;
    m_pcnt = n_pcnt;
    m_cnt  = n_cnt;
  endtask

  // One bus cycle: apply inputs, compare outputs before the edge, then step the model
  task automatic step(input logic wr, input logic rd, input logic [3:0] a, input logic [7:0] d);
    io_write = wr;
    io_read  = rd;
    io_addr  = a;
    io_wdata = d;
    #1;
    chk("rdata", 16'(io_rdata), 16'(m_rdata(a)));
    chk("irq", 16'(interrupt), 16'(m_irq));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, TMR_CTRL, 8'h00);
  endtask

  // Read a register between edges and compare with a fixed expectation
  task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string tag);
    io_write = 1'b0;
    io_read  = 1'b0;
    io_addr  = a;
    #1;
    chk(tag, 16'(io_rdata), 16'(exp));
  endtask

  initial begin
    logic [3:0] ra;
    logic [7:0] rd;
    logic       rw, rr;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    io_addr = '0; io_write = 1'b0; io_read = 1'b0; io_wdata = '0;
    model_step();

    // Reset held for two edges: everything reads back zero
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int a = 0; a < 16; a++) peek(4'(a), 8'h00, "reset_rd");
    chk("reset_irq", 16'(interrupt), 16'h0);
    rst_n = 1'b1;

    // One-shot match at CMP=0, PRESC=0, IE=0
    wr(TMR_CMP_LO, 8'h00);
    wr(TMR_PRESC, 8'h00);
    wr(TMR_CTRL, 8'h01);
    idle();
    peek(TMR_STATUS, 8'h01, "t1_pend");
    peek(TMR_CTRL, 8'h00, "t1_oneshot_stop");
    idle();
    chk("t1_irq_masked", 16'(interrupt), 16'h0);
    wr(TMR_STATUS, 8'h01);

    // Periodic: PRESC=3, CMP=2 gives a match every 12 cycles
    wr(TMR_PRESC, 8'h03);
    wr(TMR_CMP_LO, 8'h02);
    wr(TMR_CMP_HI, 8'h00);
    wr(TMR_CNT_LO, 8'h00);
    wr(TMR_CNT_HI, 8'h00);
    wr(TMR_CTRL, 8'h07);
    for (int k = 1; k <= 24; k++) begin
      if (k == 14) wr(TMR_STATUS, 8'h01);
      else idle();
      peek(TMR_STATUS, ((k >= 12 && k < 14) || k == 24) ? 8'h01 : 8'h00, "t2_pend");
      if (k == 12) chk("t2_irq_lag", 16'(interrupt), 16'h0);
      if (k == 13) chk("t2_irq_rise", 16'(interrupt), 16'h1);
      if (k == 15) chk("t2_irq_fall", 16'(interrupt), 16'h0);
    end
    wr(TMR_CTRL, 8'h00);
    wr(TMR_STATUS, 8'h01);

    // One-shot with interrupt: CMP=5, PRESC=0
    wr(TMR_CMP_LO, 8'h05);
    wr(TMR_CMP_HI, 8'h00);
    wr(TMR_PRESC, 8'h00);
    wr(TMR_CNT_LO, 8'h00);
    wr(TMR_CNT_HI, 8'h00);
    wr(TMR_CTRL, 8'h03);
    for (int k = 1; k <= 6; k++) begin
      idle();
      peek(TMR_STATUS, (k == 6) ? 8'h01 : 8'h00, "t3_pend");
    end
    peek(TMR_CTRL, 8'h02, "t3_ctrl");
    for (int k = 0; k < 20; k++) begin
      idle();
      peek(TMR_CNT_LO, 8'h05, "t3_cnt_hold");
      if (k == 0) chk("t3_irq", 16'(interrupt), 16'h1);
    end
    wr(TMR_CTRL, 8'h00);
    wr(TMR_STATUS, 8'h01);

    // Coherent 16-bit read across a carry
    wr(TMR_CMP_HI, 8'h80);
    wr(TMR_CNT_LO, 8'hFF);
    wr(TMR_CNT_HI, 8'h00);
    wr(TMR_CTRL, 8'h01);
    peek(TMR_CNT_LO, 8'hFF, "t4_lo");
    step(1'b0, 1'b1, TMR_CNT_LO, 8'h00);
    idle();
    peek(TMR_CNT_HI, 8'h00, "t4_hi_shadow");
    peek(TMR_CNT_LO, 8'h01, "t4_lo_now");
    wr(TMR_CTRL, 8'h00);

    // Match and STATUS clear in the same cycle; then CNT write during a tick
    wr(TMR_CMP_LO, 8'h03);
    wr(TMR_CMP_HI, 8'h00);
    wr(TMR_CNT_LO, 8'h00);
    wr(TMR_CNT_HI, 8'h00);
    wr(TMR_CTRL, 8'h05);
    repeat (3) idle();
    wr(TMR_STATUS, 8'h01);
    peek(TMR_STATUS, 8'h01, "t5_set_wins");
    wr(TMR_CNT_LO, 8'hFF);
    wr(TMR_CNT_LO, 8'h10);
    peek(TMR_CNT_LO, 8'h10, "t5_cnt_wr_lo");
    step(1'b0, 1'b1, TMR_CNT_LO, 8'h00);
    peek(TMR_CNT_HI, 8'h00, "t5_cnt_wr_hi");
    wr(TMR_CTRL, 8'h00);
    wr(TMR_STATUS, 8'h01);

    // 16-bit wrap: CMP=0xFFFF, CNT=0xFFFE, periodic
    wr(TMR_CMP_LO, 8'hFF);
    wr(TMR_CMP_HI, 8'hFF);
    wr(TMR_CNT_LO, 8'hFE);
    wr(TMR_CNT_HI, 8'hFF);
    wr(TMR_PRESC, 8'h00);
    wr(TMR_CTRL, 8'h05);
    step(1'b0, 1'b1, TMR_CNT_LO, 8'h00);
    peek(TMR_STATUS, 8'h00, "t6_pend_early");
    peek(TMR_CNT_HI, 8'hFF, "t6_shadow_ff");
    idle();
    peek(TMR_STATUS, 8'h01, "t6_pend");
    peek(TMR_CNT_LO, 8'h00, "t6_wrap_lo");
    step(1'b0, 1'b1, TMR_CNT_LO, 8'h00);
    peek(TMR_CNT_HI, 8'h00, "t6_wrap_hi");
    wr(TMR_CTRL, 8'h00);
    wr(TMR_STATUS, 8'h01);

    // Randomized traffic biased toward small compare/prescale values
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      ra = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      rw = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 2) == 0);
      case (ra)
        TMR_CTRL:   rd = 8'($urandom_range(0, 255)) | 8'($urandom_range(0, 2) != 0);
        TMR_PRESC:  rd = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
        TMR_CMP_LO,
        TMR_CNT_LO: rd = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
        TMR_CMP_HI,
        TMR_CNT_HI: rd = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
        default:    rd = 8'($urandom);
      endcase
      step(rw, rr, ra, rd);
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
